pong_game_ctrl: RTL

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve delay, point scoring, win detection and rematch.
// Outputs are registered; ball_load pulses on each point end and on rematch.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       ball_load,
  output logic       serve_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner
);

  localparam logic [3:0] WIN    = 4'(WIN_SCORE);
  localparam logic [7:0] FRAMES = 8'(SERVE_FRAMES);

  typedef enum logic [2:0] {IDLE, SERVE_WAIT, PLAY, POINT, OVER} state_t;

  state_t     state;
  logic [7:0] frame_cnt;
  logic       serve_q;
  logic       serve_edge;

  // serve_q resets high so a button held through reset release is not an edge
  assign serve_edge = serve & ~serve_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      frame_cnt   <= 8'd0;
      serve_q     <= 1'b1;
      ball_run    <= 1'b0;
      ball_load   <= 1'b0;
      serve_right <= 1'b1;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      serve_q   <= serve;
      ball_load <= 1'b0;
      case (state)
        IDLE: begin
          if (serve_edge) begin
            state     <= SERVE_WAIT;
            frame_cnt <= FRAMES;
          end
        end
        SERVE_WAIT: begin
          if (frame_tick && frame_cnt != 8'd0) begin
            frame_cnt <= frame_cnt - 8'd1;
            if (frame_cnt == 8'd1) begin
              state    <= PLAY;
              ball_run <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (miss_left || miss_right) begin
            state     <= POINT;
            ball_run  <= 1'b0;
            ball_load <= 1'b1;
            // a simultaneous double miss replays the point untouched
            if (miss_left && !miss_right) begin
              if (score_right != WIN) score_right <= score_right + 4'd1;
              serve_right <= 1'b0;
            end else if (miss_right && !miss_left) begin
              if (score_left != WIN) score_left <= score_left + 4'd1;
              serve_right <= 1'b1;
            end
          end
        end
        POINT: begin
          if (score_left == WIN || score_right == WIN) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= (score_right == WIN);
          end else begin
            state <= IDLE;
          end
        end
        OVER: begin
          if (serve_edge) begin
            state       <= IDLE;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            serve_right <= 1'b1;
            ball_load   <= 1'b1;
            game_over   <= 1'b0;
            winner      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
